adder_flex_pipe: RTL

Pipelined, parameterised add/subtract unit. It extends the flexible-width CLA adder family with a configurable number of register stages, a valid/ready handshake with full backpressure, an add/subtract mode, and carry-out and signed-overflow flags. Each stage is a ripple of 4-bit carry-lookahead groups, so timing closes at any operand width. It sits between operand-producing logic and any consumer that needs a registered, flow-controlled sum.

---
 rtl/adder_flex_pipe_pkg.sv | 30 +++
 rtl/adder_flex_pipe_if.sv | 29 ++
 rtl/adder_flex_pipe_stage.sv | 51 +++++
 rtl/adder_flex_pipe.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/adder_flex_pipe_pkg.sv
// rtl/adder_flex_pipe_pkg.sv - shared constants, mode type and stage-partition helpers
package adder_flex_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } adder_mode_e;

  function automatic int groups(input int width);
    return (width + GROUP_W - 1) / GROUP_W;
  endfunction

  function automatic int groups_per_stage(input int width, input int stages);
    return (groups(width) + stages - 1) / stages;
  endfunction

  // Bit range of stage k: whole CLA groups, last stage clipped to the operand width
  function automatic int stage_lo(input int width, input int stages, input int k);
    return k * groups_per_stage(width, stages) * GROUP_W;
  endfunction

  function automatic int stage_hi(input int width, input int stages, input int k);
    int top;
    top = (k + 1) * groups_per_stage(width, stages) * GROUP_W;
    return ((top < width) ? top : width) - 1;
  endfunction

endpackage

// File: rtl/adder_flex_pipe_if.sv
// rtl/adder_flex_pipe_if.sv - operand/result handshake bundle for adder_flex_pipe
interface adder_flex_pipe_if #(
  parameter int WIDTH = 15
);
  import adder_flex_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_cout;
  logic             o_ovf;

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_s, o_cout, o_ovf
  );

  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_s, o_cout, o_ovf
  );

endinterface

// File: rtl/adder_flex_pipe_stage.sv
// rtl/adder_flex_pipe_stage.sv - combinational slice adder: ripple of 4-bit CLA groups
module adder_flex_stage
  import adder_flex_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               cmsb
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] c;
  logic               bc;
  logic               gg;
  logic               gp;
  logic               gcar;

  assign p = a ^ b;
  assign g = a & b;

  // Bit carries ripple inside a group; group carry-out uses group G/P lookahead
  always_comb begin
    c    = '0;
    gcar = cin;
    bc   = cin;
    gg   = 1'b0;
    gp   = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i] = bc;
      bc   = g[i] | (p[i] & bc);
      gg   = g[i] | (p[i] & gg);
      gp   = gp & p[i];
      if ((i % GROUP_W == GROUP_W - 1) || (i == SLICE_W - 1)) begin
        gcar = gg | (gp & gcar);
        bc   = gcar;
        gg   = 1'b0;
        gp   = 1'b1;
      end
    end
  end

  assign s    = p ^ c;
  assign cout = gcar;
  assign cmsb = c[SLICE_W-1];

endmodule

// File: rtl/adder_flex_pipe.sv
// rtl/adder_flex_pipe.sv - pipelined add/subtract unit with valid/ready backpressure
module adder_flex_pipe
  import adder_flex_pkg::*;
#(
  parameter int WIDTH  = 15,
  parameter int STAGES = 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  adder_flex_pipe_if.slave bus
);

  localparam int Q    = groups(WIDTH);
  localparam int G    = groups_per_stage(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (WIDTH < 1) begin : g_chk_width
    $error("adder_flex_pipe: WIDTH must be at least 1");
  end
  if (STAGES < 1 || (STAGES - 1) * G >= Q) begin : g_chk_stages
    $error("adder_flex_pipe: STAGES leaves a stage without CLA groups");
  end

  adder_mode_e      mode;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign mode    = adder_mode_e'(bus.i_sub);
  assign b_eff   = (mode == SUB) ? ~bus.i_b : bus.i_b;
  assign cin_eff = bus.i_cin ^ (mode == SUB);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic              valid_d [STAGES];
  logic [WIDTH-1:0]  s_q     [STAGES];
  logic [WIDTH-1:0]  s_d     [STAGES];
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  b_d     [STAGES];
  logic              c_q     [STAGES];
  logic              c_d     [STAGES];
  logic              cmsb_w  [STAGES];
  logic              cmsb_q;

  // A stage takes new content when empty or when its own content moves on
  always_comb begin
    load       = '0;
    load[LAST] = !valid_q[LAST] || bus.i_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || load[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = stage_lo(WIDTH, STAGES, k);
    localparam int HI = stage_hi(WIDTH, STAGES, k);
    localparam int SW = HI - LO + 1;

    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             v_src;
    logic [SW-1:0]    sum;
    logic             cout;
    logic             cmsb;
    logic [WIDTH-1:0] s_merge;

    if (k == 0) begin : g_head
      assign a_src = bus.i_a;
      assign b_src = b_eff;
      assign s_src = '0;
      assign c_src = cin_eff;
      assign v_src = bus.i_valid;
    end else begin : g_body
      assign a_src = a_q[k-1];
      assign b_src = b_q[k-1];
      assign s_src = s_q[k-1];
      assign c_src = c_q[k-1];
      assign v_src = valid_q[k-1];
    end

    adder_flex_stage #(
      .SLICE_W(SW)
    ) u_stage (
      .a    (a_src[HI:LO]),
      .b    (b_src[HI:LO]),
      .cin  (c_src),
      .s    (sum),
      .cout (cout),
      .cmsb (cmsb)
    );

    always_comb begin
      s_merge        = s_src;
      s_merge[HI:LO] = sum;
    end

    assign s_d[k]     = s_merge;
    assign a_d[k]     = a_src;
    assign b_d[k]     = b_src;
    assign c_d[k]     = cout;
    assign valid_d[k] = v_src;
    assign cmsb_w[k]  = cmsb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      cmsb_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_d[k];
          s_q[k]     <= s_d[k];
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          c_q[k]     <= c_d[k];
        end
      end
      if (load[LAST]) begin
        cmsb_q <= cmsb_w[LAST];
      end
    end
  end

  assign bus.o_ready = load[0];
  assign bus.o_valid = valid_q[LAST];
  assign bus.o_s     = s_q[LAST];
  assign bus.o_cout  = c_q[LAST];
  assign bus.o_ovf   = cmsb_q ^ c_q[LAST];

endmodule
